// File: rtl/wallace_mul_unit.sv
// Pipelined RV32M multiplier built on a Wallace tree of full/half-adder cells; 3-cycle latency.
// A stall (out_valid && !out_ready) freezes every stage; flush clears all stage valids.

package wallace_mul_pkg;
    function automatic int wt_next(input int n);
        return (n / 3) * 2 + n % 3;
    endfunction

    function automatic int wt_rows_at(input int n, input int lvl);
        int r;
        r = n;
        for (int k = 0; k < lvl; k++) r = wt_next(r);
        return r;
    endfunction

    function automatic int wt_levels(input int n);
        int r;
        int c;
        r = n;
        c = 0;
        while (r > 2) begin
            r = wt_next(r);
            c++;
        end
        return c;
    endfunction
endpackage

module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);
    assign s  = a ^ b;
    assign co = a & b;
endmodule

module wallace_reduce
    import wallace_mul_pkg::*;
#(
    parameter int PW   = 64,
    parameter int NIN  = 33,
    parameter int NLVL = 4,
    parameter int NOUT = 7
) (
    input  logic [PW-1:0] rows_in  [NIN],
    output logic [PW-1:0] rows_out [NOUT]
);
    logic [PW-1:0] lv [NLVL+1][NIN];

    for (genvar r = 0; r < NIN; r++) begin : g_in
        assign lv[0][r] = rows_in[r];
    end

    // Each level compresses row triples with full adders; a leftover pair goes through half adders.
    for (genvar k = 0; k < NLVL; k++) begin : g_lvl
        localparam int NC = wt_rows_at(NIN, k);
        localparam int NG = NC / 3;
        localparam int NR = NC % 3;
        localparam int NN = wt_rows_at(NIN, k + 1);

        for (genvar g = 0; g < NG; g++) begin : g_fa
            logic [PW-1:0] s;
            logic [PW-1:0] c;
            wire unused_cmsb = c[PW-1];
            for (genvar j = 0; j < PW; j++) begin : g_bit
                fulladder u_fa (
                    .a (lv[k][3*g][j]),
                    .b (lv[k][3*g+1][j]),
                    .ci(lv[k][3*g+2][j]),
                    .s (s[j]),
                    .co(c[j])
                );
            end
            assign lv[k+1][2*g]   = s;
            assign lv[k+1][2*g+1] = {c[PW-2:0], 1'b0};
        end

        if (NR == 2) begin : g_ha
            logic [PW-1:0] s;
            logic [PW-1:0] c;
            wire unused_cmsb = c[PW-1];
            for (genvar j = 0; j < PW; j++) begin : g_bit
                halfadder u_ha (
                    .a (lv[k][3*NG][j]),
                    .b (lv[k][3*NG+1][j]),
                    .s (s[j]),
                    .co(c[j])
                );
            end
            assign lv[k+1][2*NG]   = s;
            assign lv[k+1][2*NG+1] = {c[PW-2:0], 1'b0};
        end else if (NR == 1) begin : g_pass
            assign lv[k+1][2*NG] = lv[k][3*NG];
        end

        for (genvar r = NN; r < NIN; r++) begin : g_zero
            assign lv[k+1][r] = '0;
        end
    end

    for (genvar r = 0; r < NOUT; r++) begin : g_out
        assign rows_out[r] = lv[NLVL][r];
    end
endmodule

module wallace_mul_unit
    import wallace_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int N      = WIDTH + 1;
    localparam int PW     = 2 * WIDTH;
    localparam int LEVELS = wt_levels(N);
    localparam int SPLIT  = LEVELS / 2;
    localparam int NMID   = wt_rows_at(N, SPLIT);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    logic             adv;
    logic             s1_vld, s2_vld;
    logic [1:0]       s1_op, s2_op;
    logic [TAG_W-1:0] s1_tag, s2_tag;
    logic [N-1:0]     a_x, b_x;
    logic [PW-1:0]    pp      [N];
    logic [PW-1:0]    mid     [NMID];
    logic [PW-1:0]    s1_rows [NMID];
    logic [PW-1:0]    fin     [2];
    logic [PW-1:0]    s2_sum, s2_cry;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] res_sel;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !flush;

    // Baugh-Wooley rows for a signed (WIDTH+1)x(WIDTH+1) product, kept modulo 2^(2*WIDTH).
    // The +2^N correction sits in row 0 just above its own bits; the 2^(2N-1) term falls off the top.
    always_comb begin
        a_x = {((in_op == OP_MULH) || (in_op == OP_MULHSU)) && in_a[WIDTH-1], in_a};
        b_x = {(in_op == OP_MULH) && in_b[WIDTH-1], in_b};
        for (int i = 0; i < N; i++) begin
            pp[i] = '0;
            for (int j = 0; j < N; j++) begin
                if (i + j < PW)
                    pp[i][i+j] = (a_x[j] & b_x[i]) ^ ((i == N - 1) != (j == N - 1));
            end
        end
        pp[0][N] = 1'b1;
    end

    wallace_reduce #(.PW(PW), .NIN(N), .NLVL(SPLIT), .NOUT(NMID)) u_red_s1 (
        .rows_in (pp),
        .rows_out(mid)
    );

    wallace_reduce #(.PW(PW), .NIN(NMID), .NLVL(LEVELS - SPLIT), .NOUT(2)) u_red_s2 (
        .rows_in (s1_rows),
        .rows_out(fin)
    );

    assign prod    = s2_sum + s2_cry;
    assign res_sel = (s2_op == OP_MUL) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld     <= 1'b0;
            s2_vld     <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            if (flush) begin
                s1_vld    <= 1'b0;
                s2_vld    <= 1'b0;
                out_valid <= 1'b0;
            end else if (adv) begin
                s1_vld    <= in_valid;
                s2_vld    <= s1_vld;
                out_valid <= s2_vld;
            end
            if (adv && s2_vld) begin
                out_result <= res_sel;
                out_tag    <= s2_tag;
            end
        end
    end

    // Payload only moves with a valid beat, so a held stage keeps its contents.
    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_rows <= mid;
            s1_op   <= in_op;
            s1_tag  <= in_tag;
        end
        if (adv && s1_vld) begin
            s2_sum <= fin[0];
            s2_cry <= fin[1];
            s2_op  <= s1_op;
            s2_tag <= s1_tag;
        end
    end
endmodule

// File: tb/tb_wallace_mul_unit.sv
// Bench for wallace_mul_unit: directed latency/flush/stall/reset cases plus a randomized
// stream checked against a queue-based model of the multiply results.
module tb_wallace_mul_unit;
    localparam int W  = 32;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]    in_op;
    logic [W-1:0]  in_a, in_b, out_result;
    logic [TW-1:0] in_tag, out_tag;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0]  mq_res [$];
    logic [TW-1:0] mq_tag [$];
    logic [W-1:0]  exp_res[$];
    int            got_k  [$];
    logic [W-1:0]  got_res[$];
    logic [TW-1:0] got_tag[$];

    wallace_mul_unit #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full-precision product of the operands as the ISA defines them.
    function automatic logic [W-1:0] ref_mul(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [127:0] ax, bx, p;
        logic sa, sb;
        sa = (op == 2'b01) || (op == 2'b10);
        sb = (op == 2'b01);
        ax = {{96{sa & a[W-1]}}, a};
        bx = {{96{sb & b[W-1]}}, b};
        p  = ax * bx;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    task automatic clear_got();
        got_k.delete();
        got_res.delete();
        got_tag.delete();
        exp_res.delete();
    endtask

    task automatic collect(input int k);
        if (out_valid && out_ready) begin
            got_k.push_back(k);
            got_res.push_back(out_result);
            got_tag.push_back(out_tag);
        end
    endtask

    task automatic run_single(input string name, input logic [1:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [TW-1:0] tag, input logic [W-1:0] exp);
        int c0;
        bit seen;
        present(op, a, b, tag);
        c0 = cyc;
        @(negedge clk);
        check({name, "_rdy"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check({name, "_seen"}, seen, 1'b1);
        if (seen) begin
            check({name, "_lat"}, cyc - c0, 3);
            check({name, "_res"}, out_result, exp);
            check({name, "_tag"}, out_tag, tag);
        end
        tick();
    endtask

    task automatic model_cycle();
        @(negedge clk);
        if (flush) check("rnd_flush_rdy", in_ready, 1'b0);
        if (mq_res.size() == 0) begin
            check("rnd_spurious_vld", out_valid, 1'b0);
        end else if (out_valid && out_ready) begin
            check("rnd_res", out_result, mq_res.pop_front());
            check("rnd_tag", out_tag, mq_tag.pop_front());
        end
        if (flush) begin
            mq_res.delete();
            mq_tag.delete();
        end else if (in_valid && in_ready) begin
            mq_res.push_back(ref_mul(in_op, in_a, in_b));
            mq_tag.push_back(in_tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0]   rop;
        int           nv;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
        in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_vld", out_valid, 1'b0);
        check("rst_res", out_result, 32'd0);
        check("rst_tag", out_tag, 5'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        check("rst_rdy", in_ready, 1'b1);
        tick();

        run_single("mul_neg",     2'b00, 32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB);
        run_single("mulh_min",    2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000);
        run_single("mulhu_max",   2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE);
        run_single("mulhsu_max",  2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF);
        run_single("mulh_neg1",   2'b01, 32'hFFFF_FFFF, 32'd1,         5'd7, 32'hFFFF_FFFF);

        // Four back-to-back operations
        clear_got();
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b0;
            if (k < 4) begin
                ra = pick(); rb = pick(); rop = 2'($urandom_range(0, 3));
                present(rop, ra, rb, TW'(k + 1));
                exp_res.push_back(ref_mul(rop, ra, rb));
            end
            @(negedge clk);
            collect(k);
            tick();
        end
        check("b2b_count", got_k.size(), 4);
        for (int i = 0; i < got_k.size() && i < 4; i++) begin
            check("b2b_cycle", got_k[i], 3 + i);
            check("b2b_tag", got_tag[i], i + 1);
            check("b2b_res", got_res[i], exp_res[i]);
        end

        // Three in flight, consumer stalls for five cycles
        clear_got();
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b0;
            if (k < 3) begin
                ra = pick(); rb = pick(); rop = 2'($urandom_range(0, 3));
                present(rop, ra, rb, TW'(10 + k));
                exp_res.push_back(ref_mul(rop, ra, rb));
            end
            out_ready = !(k >= 3 && k <= 7);
            @(negedge clk);
            if (k >= 3 && k <= 7) begin
                check("stall_rdy", in_ready, 1'b0);
                check("stall_vld", out_valid, 1'b1);
                check("stall_res", out_result, exp_res[0]);
                check("stall_tag", out_tag, 5'd10);
            end
            collect(k);
            tick();
        end
        check("stall_count", got_k.size(), 3);
        for (int i = 0; i < got_k.size() && i < 3; i++) begin
            check("stall_out_res", got_res[i], exp_res[i]);
            check("stall_out_tag", got_tag[i], 10 + i);
        end

        // Flush with two in flight and a simultaneous offer, then a fresh MUL
        clear_got();
        out_ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            in_valid = 1'b0;
            flush = 1'b0;
            if (k < 2) present(2'b00, pick(), pick(), TW'(20 + k));
            if (k == 2) begin
                present(2'b11, pick(), pick(), 5'd22);
                flush = 1'b1;
            end
            if (k == 3) present(2'b00, 32'd5, 32'd6, 5'd7);
            @(negedge clk);
            if (k == 2) check("flush_rdy", in_ready, 1'b0);
            collect(k);
            tick();
        end
        check("flush_count", got_k.size(), 1);
        if (got_k.size() > 0) begin
            check("flush_cycle", got_k[0], 6);
            check("flush_res", got_res[0], 32'd30);
            check("flush_tag", got_tag[0], 5'd7);
        end

        // Flush while the output is stalled
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b0;
            flush = 1'b0;
            out_ready = 1'b1;
            if (k < 2) present(2'b01, pick(), pick(), TW'(8 + k));
            if (k == 3) out_ready = 1'b0;
            if (k == 4) begin
                out_ready = 1'b0;
                flush = 1'b1;
            end
            @(negedge clk);
            if (k == 4) check("fstall_vld_during", out_valid, 1'b1);
            if (k >= 5) check("fstall_vld_after", out_valid, 1'b0);
            tick();
        end
        flush = 1'b0;
        out_ready = 1'b1;

        // Asynchronous reset with three in flight
        for (int k = 0; k < 3; k++) begin
            ra = pick() | 32'd1; rb = pick() | 32'd1;
            present(2'b11, ra | 32'h8000_0000, rb | 32'h8000_0000, TW'(25 + k));
            tick();
        end
        in_valid = 1'b0;
        check("arst_pre_vld", out_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("arst_vld", out_valid, 1'b0);
        check("arst_res", out_result, 32'd0);
        check("arst_tag", out_tag, 5'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        nv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("arst_no_stale", nv, 0);
        tick();
        run_single("post_rst", 2'b00, 32'd12345, 32'd678, 5'd9, 32'd8369910);

        // Randomized stream with stalls and occasional flushes
        mq_res.delete();
        mq_tag.delete();
        for (int k = 0; k < 500; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_op     = 2'($urandom_range(0, 3));
            in_a      = pick();
            in_b      = pick();
            in_tag    = TW'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0);
            model_cycle();
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            model_cycle();
            tick();
        end
        check("rnd_left", mq_res.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wallace_mul_unit.md
# wallace_mul_unit

Parametrised, pipelined Wallace-tree multiplier for the RV32M execute stage. It is built from the team's half-adder/full-adder 3:2 compressor cells and adds the final-stage carry-propagate adder. The block accepts one MUL/MULH/MULHSU/MULHU operation per cycle over a valid/ready handshake and returns the selected W-bit result after a fixed 3-cycle latency. It supports backpressure and pipeline flush for branch mispredicts.

## Interface
- WIDTH, 32: operand and result width in bits (≥ 4, even).
- TAG_W, 5: width of the opaque tag (destination register index) carried alongside each operation.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- flush  in  1  kill every in-flight operation this cycle.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts the offered operation this cycle.
- in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- in_a  in  WIDTH  multiplicand (rs1).
- in_b  in  WIDTH  multiplier (rs2).
- in_tag  in  TAG_W  tag returned with result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result this cycle.
- out_result  out  WIDTH  selected product bits.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Three registered stages, each with a valid bit, op, tag and data:
  - S1: sign/zero-extend operands to WIDTH+1 bits, then generate the partial products.
  - S2: Wallace reduction of the partial products to two rows.
  - S3: carry-propagate add and result select.
- Operand extension:
  - in_a is signed for MULH and MULHSU, unsigned otherwise.
  - in_b is signed for MULH only.
  - MUL ignores signedness for the low half.
- Partial products: (WIDTH+1)×(WIDTH+1) signed product via Baugh-Wooley rows (inverted MSB terms plus correction constant). Intermediate width is 2·WIDTH+2; bits above 2·WIDTH−1 are discarded.
- Reduction uses only halfadder/fulladder cells. The column-wise Wallace schedule is split across S1/S2 so that S2 outputs exactly two rows (sum, carry).
- Final adder: 2·WIDTH-bit adder, ripple or carry-lookahead; implementation choice.
- Result select:
  - MUL → product[WIDTH−1:0].
  - Other ops → product[2·WIDTH−1:WIDTH].
- Global advance: adv = !out_valid || out_ready. When adv=0, every stage register holds.
- in_ready = adv && !flush. An operation is accepted when in_valid && in_ready.
- Bubbles are not compressed. A stall freezes all stages, including empty ones.
- flush:
  - Clears all three valid bits on the next edge, regardless of adv.
  - The input is not accepted in the flush cycle.
  - out_valid may be 1 during the flush cycle. A result handed off in that cycle (out_ready=1) counts as delivered; the consumer discards it if required.
- Tag and op travel unchanged with their data.

## Timing
- Latency: an op accepted at edge N presents out_valid=1 from edge N+3, provided no stall.
- Throughput: 1 op/cycle with out_ready held high.
- out_result and out_tag are stable while out_valid && !out_ready.
- Reset values, applied immediately on rst=0 with no clock edge needed: all stage valids 0, out_valid 0, out_result 0, out_tag 0.
- in_ready reads 1 once rst=1 and flush=0. Data registers other than the S3 outputs need not be reset.
- Reset mid-operation drops all in-flight ops. Nothing is emitted after release until a new op completes.
- Simultaneous flush and out_ready=0: flush wins and out_valid goes to 0 next cycle.
- Simultaneous in_valid and flush: the input is ignored.
- No combinational path from in_* to out_*. in_ready depends combinationally only on out_valid, out_ready and flush.

## Test plan
- MUL with in_a=7, in_b=0xFFFFFFFD (−3), tag 3: out_result 0xFFFFFFEB with tag 3 exactly 3 cycles after acceptance.
- Signed/unsigned high-half ops:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MULH 0xFFFFFFFF×0x00000001 → 0xFFFFFFFF.
- Four back-to-back ops, tags 1–4, out_ready=1: out_valid high on 4 consecutive cycles starting 3 cycles after the first accept, tags in order 1,2,3,4.
- Three ops in flight, out_ready low for 5 cycles: in_ready=0 throughout, out_result/out_tag unchanged, no op lost or duplicated after release.
- flush asserted with 2 ops in flight plus in_valid=1 in the same cycle: none of these three produce out_valid. A MUL 5×6 issued on the next cycle returns 30 after 3 cycles.
- rst driven low between clock edges with 3 ops in flight: out_valid and out_result go to 0 before the next edge. No stale result appears after rst returns high.
